// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache backing-memory responder: FSM encoding,
// burst-type constants and address-split helpers.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Burst type as driven on req_write by the cache miss FSM.
    localparam logic BURST_READ  = 1'b0;
    localparam logic BURST_WRITE = 1'b1;

    function automatic int beat_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Byte-offset bits of a line: word-in-line bits plus the two byte bits.
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage for the responder: synchronous write, asynchronous read.
// Contents are deliberately not reset so data survives a controller reset.
module mem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency main-memory model answering cache refill and write-back bursts,
// one request at a time, completing in order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request (req_ready high once out of reset)
// ST_WAIT | latency countdown, no beats offered or accepted
// ST_RD   | offering refill beats, advancing on rdata handshake
// ST_WR   | accepting write-back beats, each committed at its edge
// ST_DONE | one-cycle wr_done pulse after the final write beat
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    input  logic              rdata_ready,
    output logic              wr_done,
    output logic              busy
);

    localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
    localparam int BEAT_W      = beat_w(LINE_WORDS);
    localparam int IDX_W       = $clog2(DEPTH_WORDS);
    localparam int LINE_IDX_W  = IDX_W - BEAT_W;
    localparam int LAT_W       = $clog2(LATENCY + 1);

    state_t                  state_q, state_d;
    logic                    out_en_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [LINE_IDX_W-1:0]   line_q;
    logic [LAT_W-1:0]        lat_cnt_q;
    logic                    write_q;
    logic                    accept;
    logic                    last_beat;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_idx;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    unused_addr_bits;

    // Only the line-index bits matter: low offset bits align, high bits alias.
    assign unused_addr_bits = ^{req_addr[OFFSET_BITS-1:0],
                                req_addr[ADDR_W-1:OFFSET_BITS+LINE_IDX_W]};

    assign accept    = (state_q == ST_IDLE) && out_en_q && req_valid;
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign mem_idx   = {line_q, beat_q};
    assign mem_we    = (state_q == ST_WR) && wdata_valid;
    assign busy      = (state_q != ST_IDLE);
    assign rdata     = rdata_valid ? mem_rdata : '0;

    // Keeps req_ready low while reset is held and releases it on the first edge after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        wr_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = out_en_q;
                if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = (write_q == BURST_WRITE) ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                rdata_valid = 1'b1;
                rdata_last  = last_beat;
                if (rdata_ready && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                wdata_ready = 1'b1;
                if (wdata_valid && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wr_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter is loaded with LATENCY-1 so the exit edge is LATENCY edges after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q    <= '0;
            line_q    <= '0;
            lat_cnt_q <= '0;
            write_q   <= BURST_READ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        line_q    <= req_addr[OFFSET_BITS +: LINE_IDX_W];
                        write_q   <= req_write;
                        beat_q    <= '0;
                        lat_cnt_q <= LAT_W'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                ST_RD: begin
                    if (rdata_ready) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_WR: begin
                    if (wdata_valid) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_idx),
        .wdata (wdata),
        .raddr (mem_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: drives at negedge, samples at negedge,
// counts handshakes and wr_done pulses at posedge.
module tb_cache_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        wdata_ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        rdata_last;
    logic        rdata_ready;
    logic        wr_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    logic [31:0] rd_d [4];
    logic        rd_l [4];
    int          rd_lat;
    int          rd_cycles;
    int          rd_beats;
    int          rd_stable_bad;

    cache_mem_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wdata_valid (wdata_valid),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .rdata_ready (rdata_ready),
        .wr_done     (wr_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (wr_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input int abort_after, input bit junk);
        logic [31:0] d [4];
        int b = 0;
        int guard = 0;
        bit hs;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        wait_ready();
        step();
        req_valid = 1'b0;
        while (b < abort_after && guard < 50) begin
            wdata_valid = 1'b1;
            wdata = (junk && !wdata_ready) ? 32'hBAD0_0BAD : d[b];
            hs = wdata_ready;
            step();
            if (hs) b++;
            guard++;
        end
        wdata_valid = 1'b0;
        wdata = '0;
        checks++;
        if (b != abort_after) begin
            errors++;
            $display("FAIL write_beats_timeout: beats=%0d required %0d", b, abort_after);
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input bit keep_valid, input bit stall);
        int guard = 0;
        bit seen = 0;
        bit stall_now;
        bit have_prev = 0;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        stall_now = stall;
        rd_lat = 0; rd_cycles = 0; rd_beats = 0; rd_stable_bad = 0;
        for (int i = 0; i < 4; i++) begin rd_d[i] = 'x; rd_l[i] = 1'bx; end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        wait_ready();
        step();
        if (!keep_valid) req_valid = 1'b0;
        while (guard < 60) begin
            if (!busy) break;
            rd_cycles++;
            if (!rdata_valid) begin
                if (!seen) rd_lat++;
                rdata_ready = 1'b0;
            end else begin
                seen = 1;
                if (have_prev && (rdata !== prev_d || rdata_last !== prev_l)) rd_stable_bad++;
                if (stall_now) begin
                    rdata_ready = 1'b0;
                    prev_d = rdata;
                    prev_l = rdata_last;
                    have_prev = 1;
                end else begin
                    rdata_ready = 1'b1;
                    if (rd_beats < 4) begin
                        rd_d[rd_beats] = rdata;
                        rd_l[rd_beats] = rdata_last;
                    end
                    rd_beats++;
                    have_prev = 0;
                end
                if (stall) stall_now = !stall_now;
            end
            step();
            guard++;
        end
        rdata_ready = 1'b0;
        checks++;
        if (guard >= 60) begin
            errors++;
            $display("FAIL read_timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: req_ready=%0b wdata_ready=%0b rdata_valid=%0b rdata=%h last=%0b wr_done=%0b busy=%0b required all 0",
                         req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy);
            end
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %0b required 1", req_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b required 0", busy);
        end
    endtask

    task automatic check_line(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        checks++;
        if (rd_beats != 4) begin
            errors++;
            $display("FAIL %s_beats: got %0d required 4", name, rd_beats);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_d[i] !== e[i]) begin
                errors++;
                $display("FAIL %s_data%0d: got %h required %h", name, i, rd_d[i], e[i]);
            end
            checks++;
            if (rd_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL %s_last%0d: got %0b required %0b", name, i, rd_l[i], (i == 3));
            end
        end
    endtask

    task automatic test_write_read();
        int d0 = done_cnt;
        write_burst(32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4, 0);
        checks++;
        if (wr_done !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_high: got %0b required 1", wr_done);
        end
        step();
        checks++;
        if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_end: wr_done=%0b req_ready=%0b required 0 and 1", wr_done, req_ready);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL wr_done_count: got %0d required 1", done_cnt - d0);
        end
        read_burst(32'h100, 0, 0);
        check_line("wr_rd", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        checks++;
        if (rd_lat != 3) begin
            errors++;
            $display("FAIL rd_latency: got %0d required 3", rd_lat);
        end
        checks++;
        if (rd_cycles != 7) begin
            errors++;
            $display("FAIL rd_cycles: got %0d required 7", rd_cycles);
        end
    endtask

    task automatic test_backpressure();
        read_burst(32'h100, 0, 1);
        check_line("bp", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        checks++;
        if (rd_stable_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: unstable stalls=%0d required 0", rd_stable_bad);
        end
        checks++;
        if (rd_cycles != 11) begin
            errors++;
            $display("FAIL bp_cycles: got %0d required 11", rd_cycles);
        end
        checks++;
        if (rd_lat != 3) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 3", rd_lat);
        end
    endtask

    task automatic test_ignored();
        int a0 = acc_cnt;
        int guard = 0;
        wdata_valid = 1'b1;
        wdata = 32'hDEAD;
        read_burst(32'h100, 1, 0);
        check_line("ign_rd", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        checks++;
        if (acc_cnt - a0 != 1) begin
            errors++;
            $display("FAIL ign_accept_during_burst: got %0d required 1", acc_cnt - a0);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ign_ready_after: got %0b required 1", req_ready);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (acc_cnt - a0 != 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_second_accept: accepts=%0d busy=%0b required 2 and 1", acc_cnt - a0, busy);
        end
        rdata_ready = 1'b1;
        while (busy && guard < 50) begin
            step();
            guard++;
        end
        rdata_ready = 1'b0;
        wdata_valid = 1'b0;
        wdata = '0;
        write_burst(32'h300, 32'h31, 32'h32, 32'h33, 32'h34, 4, 1);
        step();
        read_burst(32'h300, 0, 0);
        check_line("ign_early_wdata", 32'h31, 32'h32, 32'h33, 32'h34);
    endtask

    task automatic test_alias();
        write_burst(32'h10C, 32'h11, 32'h12, 32'h13, 32'h14, 4, 0);
        step();
        read_burst(32'h100, 0, 0);
        check_line("align", 32'h11, 32'h12, 32'h13, 32'h14);
        read_burst(32'h1100, 0, 0);
        check_line("alias", 32'h11, 32'h12, 32'h13, 32'h14);
    endtask

    task automatic test_reset_mid_write();
        int d0;
        write_burst(32'h200, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4, 0);
        step();
        d0 = done_cnt;
        write_burst(32'h200, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 2, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: busy=%0b wdata_ready=%0b required 0 and 0", busy, wdata_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midrst_wr_done: pulses=%0d required 0", done_cnt - d0);
        end
        read_burst(32'h200, 0, 0);
        check_line("midrst", 32'hC0, 32'hC1, 32'hB2, 32'hB3);
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_ignored();
        test_alias();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
